multu_hilo: RTL and testbench

- Multi-cycle unsigned shift-add multiplier that owns the Hi/Lo result registers of the EX stage.
- Sits directly upstream of the EX-stage result select: its HiOut/LoOut feed the mfhi/mflo inputs of that select.
- The select picks among ALU, Hi, Lo and shifter results.
- Accepts a multu operand pair on a Start pulse and iterates one bit per cycle. Loads Hi/Lo atomically on completion and holds them until the next completion or reset.

---
 rtl/multu_hilo.sv | 99 +++++++++
 tb/tb_multu_hilo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multu_hilo.sv
// Unsigned shift-add multiplier owning the EX-stage Hi/Lo registers.
// One multiplier bit is retired per clock; Hi/Lo load together when the product is complete.
module multu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q,  prod_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]     lo_q,    lo_d;

    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH-1:0]   prod_step;

    // The extra sum bit keeps the carry; it enters the product MSB on the right shift.
    always_comb begin
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_step = {upper_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    mcand_d = dataA;
                    prod_d  = {{WIDTH{1'b0}}, dataB};
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                    lo_d    = prod_step[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign HiOut     = hi_q;
    assign LoOut     = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: expected products queue up at Start and are checked when Done pulses.
module tb_multu_hilo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic         Start = 1'b0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;
    logic [1:0]   dbg_state;

    logic [2*W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    multu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .dataA(dataA), .dataB(dataB), .Start(Start),
        .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    // Called just after a negedge; returns 1ns after the edge that accepts Start (E0).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dataA = a;
        dataB = b;
        Start = 1'b1;
        exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Counts edges from E0 until Done is seen at a negedge; optionally pulses a
    // stray Start at edge count extra_at and watches Hi/Lo for hold violations.
    task automatic wait_done(input int extra_at, input bit check_hold,
                             input logic [W-1:0] hold_hi, input logic [W-1:0] hold_lo,
                             output int lat, output bit busy_gap,
                             output bit hold_bad, output bit timeout);
        lat = 1;
        busy_gap = 1'b0;
        hold_bad = 1'b0;
        timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (Done === 1'b1) break;
            if (Busy !== 1'b1) busy_gap = 1'b1;
            if (check_hold && (HiOut !== hold_hi || LoOut !== hold_lo)) hold_bad = 1'b1;
            if (extra_at > 0) begin
                if (lat == extra_at) begin
                    Start = 1'b1;
                    dataA = '1;
                    dataB = '1;
                end else begin
                    Start = 1'b0;
                end
            end
            if (lat >= 100) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: Busy=%b Done=%b, expected 0 0", Busy, Done);
        end
        n_cmp++;
        if (HiOut !== '0 || LoOut !== '0) begin
            n_bad++;
            $display("FAIL reset_hilo: Hi=%h Lo=%h, expected 0 0", HiOut, LoOut);
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: state=%0d, expected 0", dbg_state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ctrl: Busy=%b Done=%b, expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_products;
        logic [W-1:0]   a_tab[3];
        logic [W-1:0]   b_tab[3];
        logic [2*W-1:0] exp_v;
        int lat;
        bit gap, hbad, tout;
        a_tab[0] = 32'd3;         b_tab[0] = 32'd5;
        a_tab[1] = 32'hFFFFFFFF;  b_tab[1] = 32'hFFFFFFFF;
        a_tab[2] = 32'h00010000;  b_tab[2] = 32'h00010000;
        for (int i = 0; i < 3; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_done(0, 1'b0, '0, '0, lat, gap, hbad, tout);
            n_cmp++;
            if (tout || lat != 33) begin
                n_bad++;
                $display("FAIL product_latency[%0d]: %0d cycles (timeout=%b), expected 33", i, lat, tout);
            end
            n_cmp++;
            if (gap || Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL product_busy[%0d]: gap=%b Busy_at_done=%b, expected 0 0", i, gap, Busy);
            end
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({HiOut, LoOut} !== exp_v) begin
                n_bad++;
                $display("FAIL product_value[%0d]: Hi=%h Lo=%h, expected %h", i, HiOut, LoOut, exp_v);
            end
            @(negedge clk);
            n_cmp++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse[%0d]: Done=%b Busy=%b one cycle later, expected 0 0", i, Done, Busy);
            end
        end
    endtask

    task automatic test_hold_ignore;
        logic [2*W-1:0] exp_v;
        int lat;
        bit gap, hbad, tout;
        start_op(32'd3, 32'd5);
        wait_done(0, 1'b0, '0, '0, lat, gap, hbad, tout);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({HiOut, LoOut} !== exp_v) begin
            n_bad++;
            $display("FAIL hold_prior: Hi=%h Lo=%h, expected %h", HiOut, LoOut, exp_v);
        end
        // Start presented in the DONE cycle must be taken.
        start_op(32'd7, 32'd9);
        wait_done(5, 1'b1, 32'd0, 32'd15, lat, gap, hbad, tout);
        n_cmp++;
        if (hbad) begin
            n_bad++;
            $display("FAIL hold_during_run: Hi/Lo moved before Done, expected 00000000/0000000f");
        end
        n_cmp++;
        if (tout || lat != 33 || gap) begin
            n_bad++;
            $display("FAIL ignore_start_latency: %0d cycles gap=%b, expected 33 0", lat, gap);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({HiOut, LoOut} !== exp_v) begin
            n_bad++;
            $display("FAIL ignore_start_value: Hi=%h Lo=%h, expected %h", HiOut, LoOut, exp_v);
        end
        start_op(32'd6, 32'd7);
        wait_done(0, 1'b0, '0, '0, lat, gap, hbad, tout);
        n_cmp++;
        if (tout || lat != 33 || gap) begin
            n_bad++;
            $display("FAIL back_to_back_latency: %0d cycles gap=%b, expected 33 0", lat, gap);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({HiOut, LoOut} !== exp_v) begin
            n_bad++;
            $display("FAIL back_to_back_value: Hi=%h Lo=%h, expected %h", HiOut, LoOut, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [2*W-1:0] exp_v;
        int lat;
        bit gap, hbad, tout;
        dataA = 32'hFFFFFFFF;
        dataB = 32'd2;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0 || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL abort_ctrl: Busy=%b Done=%b state=%0d, expected 0 0 0", Busy, Done, dbg_state);
        end
        n_cmp++;
        if (HiOut !== '0 || LoOut !== '0) begin
            n_bad++;
            $display("FAIL abort_hilo: Hi=%h Lo=%h, expected 0 0", HiOut, LoOut);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (HiOut !== '0 || LoOut !== '0 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_result: Hi=%h Lo=%h Busy=%b, expected 0 0 0", HiOut, LoOut, Busy);
        end
        start_op(32'd2, 32'd2);
        wait_done(0, 1'b0, '0, '0, lat, gap, hbad, tout);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (tout || {HiOut, LoOut} !== exp_v) begin
            n_bad++;
            $display("FAIL after_abort_value: Hi=%h Lo=%h, expected %h", HiOut, LoOut, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_products();
        test_hold_ignore();
        test_abort();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
